// File: rtl/sdp_be_client.sv
// Byte-enable client for a simple-dual-port RAM: pass-through write port,
// one-cycle read pipeline, write-collision lane merge and 2-entry response FIFO.
module sdp_be_client #(
    parameter int ABITS     = 10,
    parameter int DBITS     = 32,
    parameter int BYTEWIDTH = 8,
    parameter int NBYTES    = DBITS / BYTEWIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ABITS-1:0]  wr_addr,
    input  logic [DBITS-1:0]  wr_data,
    input  logic [NBYTES-1:0] wr_be,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ABITS-1:0]  rd_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DBITS-1:0]  rsp_data,
    output logic              ram_we,
    output logic [NBYTES-1:0] ram_be,
    output logic [ABITS-1:0]  ram_wa,
    output logic [DBITS-1:0]  ram_wd,
    output logic [ABITS-1:0]  ram_ra,
    input  logic [DBITS-1:0]  ram_rd
);

    logic              ready_q, ready_d;
    logic              inflight_q, inflight_d;
    logic [NBYTES-1:0] coll_be_q, coll_be_d;
    logic [DBITS-1:0]  coll_data_q, coll_data_d;
    logic [DBITS-1:0]  buf_q [2];
    logic [DBITS-1:0]  buf_d [2];
    logic              wptr_q, wptr_d;
    logic              rptr_q, rptr_d;
    logic [1:0]        count_q, count_d;

    logic              wr_fire;
    logic              rd_fire;
    logic              pop;
    logic [1:0]        occ;
    logic [DBITS-1:0]  cap_data;

    assign wr_ready  = ready_q;
    assign ram_we    = wr_fire;
    assign ram_be    = wr_fire ? wr_be : '0;
    assign ram_wa    = wr_addr;
    assign ram_wd    = wr_data;
    assign ram_ra    = rd_addr;
    assign rsp_valid = (count_q != 2'd0);
    assign rsp_data  = buf_q[rptr_q];

    always_comb begin
        wr_fire  = wr_valid && ready_q;
        pop      = (count_q != 2'd0) && rsp_ready;
        occ      = count_q + {1'b0, inflight_q};
        // A pop this cycle frees a slot in time for the new read's capture.
        rd_ready = ready_q && ((occ < 2'd2) || ((occ == 2'd2) && pop));
        rd_fire  = rd_valid && rd_ready;

        ready_d     = 1'b1;
        inflight_d  = rd_fire;
        coll_be_d   = (rd_fire && wr_fire && (rd_addr == wr_addr)) ? wr_be : '0;
        coll_data_d = wr_data;

        // RAM returns pre-write data on a same-cycle collision; patch the written lanes.
        cap_data = ram_rd;
        for (int i = 0; i < NBYTES; i++) begin
            if (coll_be_q[i]) begin
                cap_data[i*BYTEWIDTH +: BYTEWIDTH] = coll_data_q[i*BYTEWIDTH +: BYTEWIDTH];
            end
        end

        buf_d   = buf_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (inflight_q) begin
            buf_d[wptr_q] = cap_data;
            wptr_d        = ~wptr_q;
        end
        if (pop) begin
            rptr_d = ~rptr_q;
        end
        case ({inflight_q, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q    <= 1'b0;
            inflight_q <= 1'b0;
            coll_be_q  <= '0;
            wptr_q     <= 1'b0;
            rptr_q     <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            ready_q    <= ready_d;
            inflight_q <= inflight_d;
            coll_be_q  <= coll_be_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
        end
    end

    // Data-only storage; validity is carried entirely by the control flops above.
    always_ff @(posedge clk) begin
        coll_data_q <= coll_data_d;
        buf_q       <= buf_d;
    end

endmodule

// File: tb/tb_sdp_be_client.sv
// Directed bench for sdp_be_client with a byte-enabled registered-read RAM model.
module tb_sdp_be_client;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_valid, rd_valid, rsp_ready;
    logic        wr_ready, rd_ready, rsp_valid;
    logic [9:0]  wr_addr, rd_addr, ram_wa, ram_ra;
    logic [31:0] wr_data, rsp_data, ram_wd;
    logic [31:0] ram_rd = 32'h0;
    logic [3:0]  wr_be, ram_be;
    logic        ram_we;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [0:1023] = '{default: 32'h0};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_be[i]) mem[ram_wa][i*8 +: 8] <= ram_wd[i*8 +: 8];
            end
        end
        ram_rd <= mem[ram_ra];
    end

    sdp_be_client #(.ABITS(10), .DBITS(32), .BYTEWIDTH(8), .NBYTES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .ram_we(ram_we), .ram_be(ram_be), .ram_wa(ram_wa), .ram_wd(ram_wd),
        .ram_ra(ram_ra), .ram_rd(ram_rd)
    );

    task automatic do_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    task automatic do_read(input logic [9:0] a);
        @(negedge clk);
        rd_valid = 1'b1; rd_addr = a;
        @(posedge clk); #1;
        rd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rsp_ready = 1'b1;
        wr_valid = 1'b1; wr_addr = 10'h1; wr_data = 32'h12345678; wr_be = 4'hF;
        rd_valid = 1'b1; rd_addr = 10'h1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready: got %b want 0", wr_ready); end
        checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL reset_rd_ready: got %b want 0", rd_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
        checks++; if (ram_be !== 4'h0) begin errors++; $display("FAIL reset_ram_be: got %h want 0", ram_be); end
        wr_valid = 1'b0; rd_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL release_before_edge: got %b want 0", wr_ready); end
        @(negedge clk); #1;
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL release_wr_ready: got %b want 1", wr_ready); end
        checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL release_rd_ready: got %b want 1", rd_ready); end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        wr_valid = 1'b1; wr_addr = 10'h05; wr_data = 32'hAABBCCDD; wr_be = 4'hF;
        #1;
        checks++; if ({ram_we, ram_be} !== 5'h1F) begin errors++; $display("FAIL wr_port_en: got we=%b be=%h want we=1 be=f", ram_we, ram_be); end
        checks++; if ({ram_wa, ram_wd} !== {10'h05, 32'hAABBCCDD}) begin errors++; $display("FAIL wr_port_addr_data: got %h %h want 005 aabbccdd", ram_wa, ram_wd); end
        @(negedge clk);
        wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 10'h05;
        #1;
        checks++; if (ram_ra !== 10'h05) begin errors++; $display("FAIL rd_port_addr: got %h want 005", ram_ra); end
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL wr_idle_we: got %b want 0", ram_we); end
        @(negedge clk);
        rd_valid = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL latency_early: got rsp_valid %b want 0", rsp_valid); end
        @(negedge clk); #1;
        checks++; if ({rsp_valid, rsp_data} !== {1'b1, 32'hAABBCCDD}) begin errors++; $display("FAIL full_write_read: got v=%b %h want v=1 aabbccdd", rsp_valid, rsp_data); end
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL after_pop: got rsp_valid %b want 0", rsp_valid); end
    endtask

    task automatic test_partial();
        do_write(10'h05, 32'h11223344, 4'h5);
        @(negedge clk);
        wr_valid = 1'b1; wr_addr = 10'h05; wr_data = 32'hFFFFFFFF; wr_be = 4'h0;
        #1;
        checks++; if ({ram_we, ram_be} !== 5'h10) begin errors++; $display("FAIL zero_be_write: got we=%b be=%h want we=1 be=0", ram_we, ram_be); end
        @(posedge clk); #1;
        wr_valid = 1'b0;
        do_read(10'h05);
        repeat (2) @(negedge clk);
        #1;
        checks++; if ({rsp_valid, rsp_data} !== {1'b1, 32'hAA22CC44}) begin errors++; $display("FAIL partial_be: got v=%b %h want v=1 aa22cc44", rsp_valid, rsp_data); end
    endtask

    task automatic test_collision();
        @(negedge clk);
        wr_valid = 1'b1; wr_addr = 10'h07; wr_data = 32'hDEADBEEF; wr_be = 4'h3;
        rd_valid = 1'b1; rd_addr = 10'h07;
        @(posedge clk); #1;
        wr_valid = 1'b0; rd_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if ({rsp_valid, rsp_data} !== {1'b1, 32'h0000BEEF}) begin errors++; $display("FAIL collision_merge: got v=%b %h want v=1 0000beef", rsp_valid, rsp_data); end
        do_read(10'h07);
        repeat (2) @(negedge clk);
        #1;
        checks++; if ({rsp_valid, rsp_data} !== {1'b1, 32'h0000BEEF}) begin errors++; $display("FAIL collision_readback: got v=%b %h want v=1 0000beef", rsp_valid, rsp_data); end
    endtask

    task automatic test_backpressure();
        int accepted;
        do_write(10'h20, 32'hCAFE0020, 4'hF);
        do_write(10'h21, 32'hCAFE0021, 4'hF);
        do_write(10'h22, 32'hCAFE0022, 4'hF);
        rsp_ready = 1'b0;
        accepted = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            rd_valid = 1'b1; rd_addr = 10'h20 + 10'(accepted);
            #1;
            if (k >= 2) begin
                checks++; if ({rsp_valid, rsp_data} !== {1'b1, 32'hCAFE0020}) begin errors++; $display("FAIL stall_head_k%0d: got v=%b %h want v=1 cafe0020", k, rsp_valid, rsp_data); end
            end
            if (rd_ready) accepted++;
        end
        checks++; if (accepted !== 2) begin errors++; $display("FAIL stall_accepted: got %0d want 2", accepted); end
        checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL stall_rd_ready: got %b want 0", rd_ready); end
        @(negedge clk);
        rd_valid = 1'b0; rsp_ready = 1'b1;
        #1;
        checks++; if ({rsp_valid, rsp_data} !== {1'b1, 32'hCAFE0020}) begin errors++; $display("FAIL drain_first: got v=%b %h want v=1 cafe0020", rsp_valid, rsp_data); end
        @(negedge clk); #1;
        checks++; if ({rsp_valid, rsp_data} !== {1'b1, 32'hCAFE0021}) begin errors++; $display("FAIL drain_second: got v=%b %h want v=1 cafe0021", rsp_valid, rsp_data); end
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got rsp_valid %b want 0", rsp_valid); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) do_write(10'(i), 32'h1000 + i, 4'hF);
        rsp_ready = 1'b1;
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            if (k < 16) begin rd_valid = 1'b1; rd_addr = 10'(k); end
            else rd_valid = 1'b0;
            #1;
            if (k < 16) begin
                checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_k%0d: got %b want 1", k, rd_ready); end
            end
            if (k >= 2) begin
                checks++; if ({rsp_valid, rsp_data} !== {1'b1, 32'h1000 + 32'(k - 2)}) begin errors++; $display("FAIL b2b_rsp_k%0d: got v=%b %h want v=1 %h", k, rsp_valid, rsp_data, 32'h1000 + 32'(k - 2)); end
            end
        end
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_end: got rsp_valid %b want 0", rsp_valid); end
    endtask

    task automatic test_reset_midread();
        rsp_ready = 1'b1;
        do_read(10'h03);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if ({rsp_valid, rd_ready, wr_ready} !== 3'b000) begin errors++; $display("FAIL midreset_outputs: got v=%b rr=%b wr=%b want 000", rsp_valid, rd_ready, wr_ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL stale_rsp_k%0d: got rsp_valid %b want 0", k, rsp_valid); end
        end
        do_read(10'h03);
        repeat (2) @(negedge clk);
        #1;
        checks++; if ({rsp_valid, rsp_data} !== {1'b1, 32'h00001003}) begin errors++; $display("FAIL post_reset_read: got v=%b %h want v=1 00001003", rsp_valid, rsp_data); end
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL post_reset_empty: got rsp_valid %b want 0", rsp_valid); end
    endtask

    initial begin
        rst_n = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b1;
        wr_addr = '0; wr_data = '0; wr_be = '0; rd_addr = '0;
        test_reset();
        test_write_read();
        test_partial();
        test_collision();
        test_backpressure();
        test_back_to_back();
        test_reset_midread();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
